divmod4: RTL and testbench
==========================

# divmod4

4-bit unsigned divider/modulo unit. It computes quotient and remainder of `x / y` using a restoring-division datapath built from 5-bit subtract/carry stages, suitable for iCE40 carry-chain mapping. The core is clocked with a valid-qualified registered output and sits as a leaf arithmetic block behind a simple valid strobe. An optional compile-time pipeline split trades one extra cycle of latency for a shorter critical path.

## Interface
Parameters:
- none; all widths are fixed at 4 bits.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: when high, `x`/`y` are sampled this cycle.
- `x` input 4: unsigned dividend.
- `y` input 4: unsigned divisor.
- `out_valid` output 1: one-cycle pulse marking new `A`/`B`/`dbz`.
- `A` output 4: remainder, `x % y`.
- `B` output 4: quotient, `x / y`.
- `dbz` output 1: divide-by-zero flag for the result on `A`/`B`.

## Operation
- Restoring division, MSB first, four stages. Start with rem=0. For i=3 down to 0: rem = {rem[2:0], x[i]}; compute a 5-bit diff = {1'b0,rem} - {1'b0,y}. If no borrow (diff[4]==0): q[i]=1 and rem=diff[3:0]. Otherwise q[i]=0 and rem is unchanged.
- After the four stages, B=q and A=rem.
- For every y≠0, the result satisfies x == B*y + A with A < y.
- Divide by zero (y==0): the algorithm yields B=4'hF and A=x. This is the required output. `dbz`=1 for that result and 0 otherwise.
- The datapath has no signed interpretation. No intermediate value exceeds 5 bits.
- `A`, `B` and `dbz` update only when a result is delivered (`out_valid`=1). Otherwise they hold their last value.

## Timing
- Reset: `out_valid`=0, `A`=0, `B`=0, `dbz`=0, and all internal pipeline valid bits are cleared.
- Default build: latency 1. `in_valid` and `x`/`y` sampled at edge N produce `out_valid`=1 and the result after edge N, valid for exactly one cycle unless a new input was sampled at edge N+1.
- Throughput is one operation per cycle; back-to-back `in_valid` gives back-to-back `out_valid`.
- When `rst` and `in_valid` are high in the same cycle, reset wins and the input is dropped.
- Reset mid-operation discards all in-flight results. No `out_valid` appears for inputs sampled before the reset edge.

## Configuration
- `DIVMOD4_PIPE_EN`, when defined:
  - A register stage is inserted after stage 1 (bit 2 decided). It holds the partial remainder, partial quotient, remaining `x` bits, `y` and a valid bit.
  - Latency becomes 2 cycles and throughput stays one per cycle.
  - Reset clears the intermediate valid bit.
- When not defined, all four stages are combinational between the input sample and the output register, with latency 1.
- Results are bit-identical in both builds.

## Test plan
- Exhaustive sweep of all 256 {y,x} pairs with `in_valid` held high. After the configured latency, each result must match the golden model: A = x%y and B = x/y for y≠0, and B=F, A=x, dbz=1 for y=0.
- Spot values:
  - x=13, y=4 -> B=3, A=1, dbz=0.
  - x=15, y=1 -> B=15, A=0.
  - x=3, y=7 -> B=0, A=3.
  - x=9, y=0 -> B=15, A=9, dbz=1.
- Quotient bit 2 isolated: x=12, y=3 -> B=4 (B[2]=1). x=11, y=3 -> B=3 (B[2]=0).
- Valid gating: pulse `in_valid` once with x=14, y=5. Expect exactly one `out_valid` pulse with B=2, A=4, then A/B held while `in_valid`=0.
- Reset: assert `rst` the cycle after issuing x=8, y=2. Expect no `out_valid`, and all outputs 0 after the reset edge.
- With `DIVMOD4_PIPE_EN`: a back-to-back stream of 0..255 yields identical results delayed by 2 cycles, with no bubbles.

Source files
------------

// File: rtl/divmod4.sv
// divmod4 -- 4-bit unsigned divider/modulo unit.
//
// Restoring division, MSB first, four 5-bit subtract stages. The result
// register is qualified by a one-cycle out_valid pulse; A/B/dbz hold their
// last delivered value between pulses.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   in_valid  x/y are sampled on this edge
//   x, y      unsigned dividend / divisor
//   out_valid one-cycle pulse marking a new A/B/dbz
//   A         remainder  (x % y; x when y == 0)
//   B         quotient   (x / y; 4'hF when y == 0)
//   dbz       divide-by-zero flag for the result on A/B
//
// Build option:
//   DIVMOD4_PIPE_EN  when defined, registers the datapath after the stage
//                    that decides quotient bit 2 (latency 2, throughput 1).
//                    Otherwise all four stages feed the output register
//                    directly (latency 1).

module divmod4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       out_valid,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       dbz
);

  // One restoring step: returns {quotient bit, new partial remainder}.
  // The bit shifted out of rem[3] is always zero here because before the
  // last shift the partial remainder is bounded by x[3:1] (<= 7).
  function automatic logic [4:0] div_stage(input logic [3:0] rem,
                                           input logic       xb,
                                           input logic [3:0] d);
    logic [3:0] sh;
    logic [4:0] diff;
    sh   = {rem[2:0], xb};
    diff = {1'b0, sh} - {1'b0, d};
    if (diff[4]) div_stage = {1'b0, sh};
    else         div_stage = {1'b1, diff[3:0]};
  endfunction

  logic       fin_valid;
  logic [3:0] fin_rem;
  logic [3:0] fin_q;
  logic       fin_dbz;

`ifdef DIVMOD4_PIPE_EN

  // Front half: stages for quotient bits 3 and 2.
  logic [4:0] s3, s2;
  always_comb begin
    s3 = div_stage(4'd0,     x[3], y);
    s2 = div_stage(s3[3:0],  x[2], y);
  end

  // Split register: partial remainder, partial quotient, unused x bits, y.
  logic       p_valid;
  logic [3:0] p_rem;
  logic [1:0] p_q;
  logic [1:0] p_x;
  logic [3:0] p_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_rem   <= '0;
      p_q     <= '0;
      p_x     <= '0;
      p_y     <= '0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        p_rem <= s2[3:0];
        p_q   <= {s3[4], s2[4]};
        p_x   <= x[1:0];
        p_y   <= y;
      end
    end
  end

  // Back half: stages for quotient bits 1 and 0.
  logic [4:0] s1, s0;
  always_comb begin
    s1        = div_stage(p_rem,   p_x[1], p_y);
    s0        = div_stage(s1[3:0], p_x[0], p_y);
    fin_valid = p_valid;
    fin_rem   = s0[3:0];
    fin_q     = {p_q, s1[4], s0[4]};
    fin_dbz   = (p_y == 4'd0);
  end

`else

  logic [4:0] s3, s2, s1, s0;
  always_comb begin
    s3        = div_stage(4'd0,    x[3], y);
    s2        = div_stage(s3[3:0], x[2], y);
    s1        = div_stage(s2[3:0], x[1], y);
    s0        = div_stage(s1[3:0], x[0], y);
    fin_valid = in_valid;
    fin_rem   = s0[3:0];
    fin_q     = {s3[4], s2[4], s1[4], s0[4]};
    fin_dbz   = (y == 4'd0);
  end

`endif

  // Output register: results only load on a delivered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      dbz       <= 1'b0;
    end else begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        A   <= fin_rem;
        B   <= fin_q;
        dbz <= fin_dbz;
      end
    end
  end

endmodule

// File: tb/tb_divmod4.sv
// Self-checking bench for divmod4. The reference model computes results with
// plain / and % arithmetic and delays them through a queue of the configured
// latency; A/B/dbz are modelled as holding between valid pulses.

module tb_divmod4;

`ifdef DIVMOD4_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] x;
  logic [3:0] y;
  logic       out_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       dbz;

  divmod4 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .A        (A),
    .B        (B),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [3:0] x;
    logic [3:0] y;
  } req_t;

  req_t inflight[$];

  // Model outputs
  logic       e_ov;
  logic [3:0] e_a;
  logic [3:0] e_b;
  logic       e_dbz;

  task automatic model_reset();
    req_t blank;
    blank.v = 1'b0;
    blank.x = 4'd0;
    blank.y = 4'd0;
    inflight.delete();
    for (int i = 0; i < LAT - 1; i++) inflight.push_back(blank);
    e_ov  = 1'b0;
    e_a   = 4'd0;
    e_b   = 4'd0;
    e_dbz = 1'b0;
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic step(input logic r, input logic v, input logic [3:0] xx,
                      input logic [3:0] yy);
    req_t n, o;
    rst      = r;
    in_valid = v;
    x        = xx;
    y        = yy;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      n.v = v;
      n.x = xx;
      n.y = yy;
      inflight.push_back(n);
      o    = inflight.pop_front();
      e_ov = o.v;
      if (o.v) begin
        if (o.y == 4'd0) begin
          e_a   = o.x;
          e_b   = 4'hF;
          e_dbz = 1'b1;
        end else begin
          e_a   = o.x % o.y;
          e_b   = o.x / o.y;
          e_dbz = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd5, 4'd2);
    total++;
    if ({out_valid, A, B, dbz} !== 10'd0) begin
      bad++;
      $display("FAIL reset: got ov=%b A=%0d B=%0d dbz=%b want all 0",
               out_valid, A, B, dbz);
    end
    step(1'b0, 1'b0, 4'd0, 4'd0);
    total++;
    if ({out_valid, A, B, dbz} !== 10'd0) begin
      bad++;
      $display("FAIL reset_release: got ov=%b A=%0d B=%0d dbz=%b want all 0",
               out_valid, A, B, dbz);
    end
  endtask

  task automatic test_spot();
    logic [3:0] tx[8] = '{4'd13, 4'd15, 4'd3, 4'd9, 4'd12, 4'd11, 4'd0, 4'd15};
    logic [3:0] ty[8] = '{4'd4,  4'd1,  4'd7, 4'd0, 4'd3,  4'd3,  4'd0, 4'd15};
    logic [3:0] tb[8] = '{4'd3,  4'd15, 4'd0, 4'd15, 4'd4, 4'd3,  4'd15, 4'd1};
    logic [3:0] ta[8] = '{4'd1,  4'd0,  4'd3, 4'd9, 4'd0,  4'd2,  4'd0, 4'd0};
    logic       td[8] = '{1'b0,  1'b0,  1'b0, 1'b1, 1'b0,  1'b0,  1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, tx[i], ty[i]);
      for (int k = 1; k < LAT; k++) step(1'b0, 1'b0, 4'd0, 4'd0);
      total++;
      if ({out_valid, B, A, dbz} !== {1'b1, tb[i], ta[i], td[i]}) begin
        bad++;
        $display("FAIL spot x=%0d y=%0d: got ov=%b B=%0d A=%0d dbz=%b want ov=1 B=%0d A=%0d dbz=%b",
                 tx[i], ty[i], out_valid, B, A, dbz, tb[i], ta[i], td[i]);
      end
    end
  endtask

  task automatic test_valid_gating();
    int pulses = 0;
    step(1'b0, 1'b1, 4'd14, 4'd5);
    if (out_valid === 1'b1) pulses++;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
      if (out_valid === 1'b1) pulses++;
      if (k >= LAT - 1) begin
        total++;
        if ({out_valid, B, A, dbz} !== {1'b0, 4'd2, 4'd4, 1'b0}) begin
          bad++;
          $display("FAIL gating_hold k=%0d: got ov=%b B=%0d A=%0d dbz=%b want ov=0 B=2 A=4 dbz=0",
                   k, out_valid, B, A, dbz);
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL gating_pulses: got %0d out_valid pulses want 1", pulses);
    end
  endtask

  task automatic test_exhaustive();
    int ovs = 0;
    logic [7:0] p;
    for (int i = 0; i < 256 + LAT; i++) begin
      p = i[7:0];
      if (i < 256) step(1'b0, 1'b1, p[3:0], p[7:4]);
      else         step(1'b0, 1'b0, 4'd0, 4'd0);
      if (out_valid === 1'b1) ovs++;
      total++;
      if ({out_valid, A, B, dbz} !== {e_ov, e_a, e_b, e_dbz}) begin
        bad++;
        $display("FAIL sweep i=%0d: got ov=%b A=%0d B=%0d dbz=%b want ov=%b A=%0d B=%0d dbz=%b",
                 i, out_valid, A, B, dbz, e_ov, e_a, e_b, e_dbz);
      end
    end
    total++;
    if (ovs != 256) begin
      bad++;
      $display("FAIL sweep_count: got %0d out_valid cycles want 256", ovs);
    end
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(24) == 0);
      step(r, 1'($urandom_range(3) != 0), 4'($urandom_range(15)),
           4'($urandom_range(15)));
      total++;
      if ({out_valid, A, B, dbz} !== {e_ov, e_a, e_b, e_dbz}) begin
        bad++;
        $display("FAIL random i=%0d: got ov=%b A=%0d B=%0d dbz=%b want ov=%b A=%0d B=%0d dbz=%b",
                 i, out_valid, A, B, dbz, e_ov, e_a, e_b, e_dbz);
      end
    end
  endtask

  task automatic test_reset_midop();
    int late = 0;
    step(1'b0, 1'b1, 4'd8, 4'd2);
    // In the single-cycle build the result is already out before reset.
    total++;
    if (out_valid !== ((LAT == 1) ? 1'b1 : 1'b0)) begin
      bad++;
      $display("FAIL midop_pre: got ov=%b want %b", out_valid,
               (LAT == 1) ? 1'b1 : 1'b0);
    end
    step(1'b1, 1'b0, 4'd0, 4'd0);
    total++;
    if ({out_valid, A, B, dbz} !== 10'd0) begin
      bad++;
      $display("FAIL midop_reset: got ov=%b A=%0d B=%0d dbz=%b want all 0",
               out_valid, A, B, dbz);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0);
      if (out_valid !== 1'b0) late++;
    end
    total++;
    if (late != 0) begin
      bad++;
      $display("FAIL midop_flush: got %0d late out_valid cycles want 0", late);
    end
  endtask

  task automatic test_rst_and_valid();
    int seen = 0;
    step(1'b0, 1'b1, 4'd6, 4'd3);
    step(1'b1, 1'b1, 4'd7, 4'd3);
    for (int k = 0; k < LAT + 2; k++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0);
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || A !== 4'd0 || B !== 4'd0) begin
      bad++;
      $display("FAIL rst_and_valid: got %0d out_valid cycles A=%0d B=%0d want 0/0/0",
               seen, A, B);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = 4'd0;
    y        = 4'd0;
    model_reset();
    test_reset();
    test_spot();
    test_valid_gating();
    test_exhaustive();
    test_random();
    test_reset_midop();
    test_rst_and_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
